// File: rtl/reg_pw_sync_fifo.sv
// Capture FIFO with register-bus access: arm/flush/capture sequencing, length limit,
// programmable fill thresholds, fill count and saturating overflow counter.
module reg_pw_sync_fifo #(
    parameter int pDATA_WIDTH = 18,
    parameter int pDEPTH_LOG2 = 10,
    parameter int pBYTES      = 4
) (
    input  logic                   cwusb_clk,
    input  logic                   reset_i,
    input  logic [5:0]             reg_address,
    input  logic [15:0]            reg_bytecnt,
    input  logic                   reg_addrvalid,
    input  logic                   reg_read,
    input  logic                   reg_write,
    input  logic [7:0]             write_data,
    output logic [7:0]             read_data,
    input  logic [pDATA_WIDTH-1:0] I_din,
    input  logic                   I_wr,
    input  logic                   I_match,
    output logic                   O_arm,
    output logic                   O_capturing,
    output logic                   O_fifo_full
);

    // state   | meaning
    // IDLE    | capture stopped, FIFO readable
    // FLUSH   | discarding stale entries, one per cycle
    // ARMED   | waiting for I_match
    // CAPTURE | pushing I_wr entries until CAPTURE_LEN reached
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_ARMED   = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    localparam int DEPTH = 2 ** pDEPTH_LOG2;
    localparam int CW    = pDEPTH_LOG2 + 1;

    function automatic logic [31:0] put_byte(input logic [31:0] cur, input logic [15:0] idx,
                                             input logic [7:0] data);
        logic [31:0] res;
        res = cur;
        case (idx)
            16'd0:   res[7:0]   = data;
            16'd1:   res[15:8]  = data;
            16'd2:   res[23:16] = data;
            16'd3:   res[31:24] = data;
            default: ;
        endcase
        return res;
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [15:0] idx);
        case (idx)
            16'd0:   return word[7:0];
            16'd1:   return word[15:8];
            16'd2:   return word[23:16];
            16'd3:   return word[31:24];
            default: return 8'h00;
        endcase
    endfunction

    state_t                 state_q, state_d;
    logic [pDEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [CW-1:0]          full_th_q, full_th_d, empty_th_q, empty_th_d;
    logic [15:0]            cap_len_q, cap_len_d, cap_cnt_q, cap_cnt_d;
    logic [15:0]            ovf_cnt_q, ovf_cnt_d;
    logic                   udf_q, udf_d, ovf_q, ovf_d;
    logic [pDATA_WIDTH-1:0] hold_q, hold_d;
    logic [7:0]             rd_q, rd_d;
    logic [pDATA_WIDTH-1:0] fifo_mem [DEPTH];

    logic                   wr_en, rd_en, arm_wr, fifo_sel, pop_req, flush_clr;
    logic                   empty, full, pop, push, drop;
    logic [15:0]            fifo_b;
    logic [pDATA_WIDTH-1:0] head;
    logic [5:0]             stat;
    logic [31:0]            rd_word;
    logic [8*pBYTES-1:0]    fword;
    logic [7:0]             fifo_byte;

    assign wr_en    = reg_write & reg_addrvalid;
    assign rd_en    = reg_read & reg_addrvalid;
    assign arm_wr   = wr_en & (reg_address == 6'h00) & (reg_bytecnt == 16'd0);
    assign fifo_b   = reg_bytecnt % 16'(pBYTES);
    assign fifo_sel = rd_en & (reg_address == 6'h08);
    assign pop_req  = fifo_sel & (fifo_b == 16'd0);

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign pop   = (pop_req | (state_q == ST_FLUSH)) & !empty;
    assign push  = I_wr & (state_q == ST_CAPTURE) & (!full | pop);
    assign drop  = I_wr & (state_q == ST_CAPTURE) & full & !pop;
    assign head  = fifo_mem[rd_ptr_q];

    assign stat = {(count_q >= full_th_q) & !full, ovf_q, full,
                   (count_q <= empty_th_q) & !empty, udf_q, empty};

    always_comb begin
        state_d   = state_q;
        flush_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm_wr && write_data[0]) begin
                    state_d   = ST_FLUSH;
                    flush_clr = 1'b1;
                end
            end
            // count of one means this cycle's pop empties the FIFO
            ST_FLUSH:   if (empty || count_q == CW'(1)) state_d = ST_ARMED;
            ST_ARMED:   if (I_match) state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                if (push && cap_len_q != 16'd0 && cap_cnt_q + 16'd1 == cap_len_q)
                    state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
        if (arm_wr && !write_data[0]) state_d = ST_IDLE;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + pDEPTH_LOG2'(push);
        rd_ptr_d   = rd_ptr_q + pDEPTH_LOG2'(pop);
        count_d    = count_q + CW'(push) - CW'(pop);
        cap_cnt_d  = cap_cnt_q + 16'(push);
        ovf_d      = ovf_q | drop;
        ovf_cnt_d  = (drop && ovf_cnt_q != 16'hFFFF) ? ovf_cnt_q + 16'd1 : ovf_cnt_q;
        udf_d      = udf_q | (pop_req & empty);
        hold_d     = hold_q;
        cap_len_d  = cap_len_q;
        full_th_d  = full_th_q;
        empty_th_d = empty_th_q;
        // bytes above 0 of FIFO_RD come from the entry popped by the last byte-0 read
        if (pop_req) hold_d = empty ? '0 : head;
        if (flush_clr) begin
            udf_d     = 1'b0;
            ovf_d     = 1'b0;
            ovf_cnt_d = '0;
            cap_cnt_d = '0;
        end
        if (wr_en) begin
            case (reg_address)
                6'h01:   cap_len_d  = 16'(put_byte(32'(cap_len_q), reg_bytecnt, write_data));
                6'h02:   full_th_d  = CW'(put_byte(32'(full_th_q), reg_bytecnt, write_data));
                6'h03:   empty_th_d = CW'(put_byte(32'(empty_th_q), reg_bytecnt, write_data));
                default: ;
            endcase
        end
    end

    always_comb begin
        case (reg_address)
            6'h00:   rd_word = {31'b0, state_q != ST_IDLE};
            6'h01:   rd_word = 32'(cap_len_q);
            6'h02:   rd_word = 32'(full_th_q);
            6'h03:   rd_word = 32'(empty_th_q);
            6'h04:   rd_word = 32'(count_q);
            6'h05:   rd_word = 32'(ovf_cnt_q);
            6'h06:   rd_word = 32'(state_q);
            6'h07:   rd_word = 32'(stat);
            default: rd_word = 32'd0;
        endcase
        rd_d = rd_en ? get_byte(rd_word, reg_bytecnt) : 8'h00;
    end

    always_comb begin
        fword                   = '0;
        fword[pDATA_WIDTH-1:0]  = hold_q;
        fword[7:0]              = empty ? 8'h00 : head[7:0];
        fifo_byte               = {2'b00, stat};
        for (int b = 0; b < pBYTES - 1; b++) begin
            if (fifo_b == 16'(b)) fifo_byte = fword[b*8 +: 8];
        end
    end

    always_ff @(posedge cwusb_clk) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_th_q  <= '0;
            empty_th_q <= '0;
            cap_len_q  <= '0;
            cap_cnt_q  <= '0;
            ovf_cnt_q  <= '0;
            udf_q      <= 1'b0;
            ovf_q      <= 1'b0;
            hold_q     <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_th_q  <= full_th_d;
            empty_th_q <= empty_th_d;
            cap_len_q  <= cap_len_d;
            cap_cnt_q  <= cap_cnt_d;
            ovf_cnt_q  <= ovf_cnt_d;
            udf_q      <= udf_d;
            ovf_q      <= ovf_d;
            hold_q     <= hold_d;
            rd_q       <= rd_d;
        end
    end

    always_ff @(posedge cwusb_clk) begin
        if (push) fifo_mem[wr_ptr_q] <= I_din;
    end

    assign read_data   = fifo_sel ? fifo_byte : rd_q;
    assign O_arm       = (state_q == ST_ARMED);
    assign O_capturing = (state_q == ST_CAPTURE);
    assign O_fifo_full = full;

endmodule
